// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared definitions for the arbiter-PUF challenge sequencer: FSM state encoding,
// Galois LFSR tap masks per challenge width and the parameter legality rule.
package puf_challenge_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StFire   = 3'd2,
        StSample = 3'd3,
        StDecide = 3'd4,
        StDone   = 3'd5
    } state_e;

    // Right-shifting Galois masks for maximal-length sequences; 0 means unsupported width.
    function automatic logic [63:0] lfsr_mask(input int unsigned len);
        case (len)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return 64'h0000_0000_8020_0003;
            default: return 64'h0;
        endcase
    endfunction

    function automatic bit params_legal(input int unsigned c_length,
                                        input int unsigned resp_bits,
                                        input int unsigned votes,
                                        input int unsigned setup_cyc,
                                        input int unsigned settle_cyc);
        return (votes >= 1) && (votes % 2 == 1) && (setup_cyc >= 1) && (settle_cyc >= 3) &&
               (resp_bits >= 2) && (c_length <= 64) && (lfsr_mask(c_length) != 64'h0);
    endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer bringing the asynchronous arbiter output into the iclk domain.
module puf_resp_sync (
    input  logic iclk,
    input  logic irst_n,
    input  logic iasync,
    output logic osync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= iasync;
            sync_q <= meta_q;
        end
    end

    assign osync = sync_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF sequencer: walks LFSR challenges, times setup and race pulse, and
// majority-votes repeated arbiter samples into one response bit per challenge.
module puf_challenge_sequencer
    import puf_challenge_sequencer_pkg::*;
#(
    parameter int unsigned C_LENGTH   = 16,
    parameter int unsigned RESP_BITS  = 32,
    parameter int unsigned VOTES      = 5,
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic                 iclk,
    input  logic                 irst_n,
    input  logic                 istart,
    input  logic [C_LENGTH-1:0]  iseed,
    input  logic                 iabort,
    output logic [C_LENGTH-1:0]  ochallenge,
    output logic                 opulse,
    input  logic                 iresponse,
    output logic                 obusy,
    output logic                 ovalid,
    input  logic                 iack,
    output logic [RESP_BITS-1:0] oresp,
    output logic                 ounstable
);

    localparam int unsigned CntMax = (SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned VoteW  = $clog2(VOTES + 1);
    localparam int unsigned IdxW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [63:0]         TapMaskFull = lfsr_mask(C_LENGTH);
    localparam logic [C_LENGTH-1:0] TapMask     = TapMaskFull[C_LENGTH-1:0];
    localparam logic [CntW-1:0]     SetupLast   = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0]     SettleLast  = CntW'(SETTLE_CYC - 1);
    localparam logic [VoteW-1:0]    VoteLast    = VoteW'(VOTES - 1);
    localparam logic [VoteW-1:0]    VoteAll     = VoteW'(VOTES);
    localparam logic [VoteW-1:0]    VoteHalf    = VoteW'(VOTES / 2);
    localparam logic [IdxW-1:0]     IdxLast     = IdxW'(RESP_BITS - 1);

    if (!params_legal(C_LENGTH, RESP_BITS, VOTES, SETUP_CYC, SETTLE_CYC)) begin : gen_param_err
        $error("puf_challenge_sequencer: illegal parameter combination");
    end

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cyc_q, cyc_d;
    logic [VoteW-1:0]       vote_q, vote_d;
    logic [VoteW-1:0]       ones_q, ones_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [C_LENGTH-1:0]    chal_q, chal_d;
    logic [RESP_BITS-1:0]   resp_q, resp_d;
    logic                   unst_q, unst_d;
    logic                   resp_sync;
    logic [C_LENGTH-1:0]    chal_next;

    puf_resp_sync u_resp_sync (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iasync (iresponse),
        .osync  (resp_sync)
    );

    assign chal_next = chal_q[0] ? ((chal_q >> 1) ^ TapMask) : (chal_q >> 1);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        vote_d  = vote_q;
        ones_d  = ones_q;
        idx_d   = idx_q;
        chal_d  = chal_q;
        resp_d  = resp_q;
        unst_d  = unst_q;

        unique case (state_q)
            StIdle: begin
                if (istart) begin
                    // An all-zero challenge would lock the LFSR, so substitute all-ones.
                    chal_d  = (iseed == '0) ? '1 : iseed;
                    idx_d   = '0;
                    vote_d  = '0;
                    ones_d  = '0;
                    resp_d  = '0;
                    unst_d  = 1'b0;
                    cyc_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cyc_q == SetupLast) begin
                    cyc_d   = '0;
                    state_d = StFire;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StFire: begin
                if (cyc_q == SettleLast) begin
                    cyc_d   = '0;
                    state_d = StSample;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StSample: begin
                ones_d  = ones_q + VoteW'(resp_sync);
                vote_d  = vote_q + 1'b1;
                state_d = (vote_q == VoteLast) ? StDecide : StSetup;
            end
            StDecide: begin
                resp_d[idx_q] = (ones_q > VoteHalf);
                unst_d        = unst_q | ((ones_q != '0) && (ones_q != VoteAll));
                ones_d        = '0;
                vote_d        = '0;
                chal_d        = chal_next;
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StSetup;
                end
            end
            StDone: begin
                if (iack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything and freezes the partial result.
        if (iabort) begin
            state_d = StIdle;
            cyc_d   = cyc_q;
            vote_d  = vote_q;
            ones_d  = ones_q;
            idx_d   = idx_q;
            chal_d  = chal_q;
            resp_d  = resp_q;
            unst_d  = unst_q;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            vote_q  <= '0;
            ones_q  <= '0;
            idx_q   <= '0;
            chal_q  <= '0;
            resp_q  <= '0;
            unst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            vote_q  <= vote_d;
            ones_q  <= ones_d;
            idx_q   <= idx_d;
            chal_q  <= chal_d;
            resp_q  <= resp_d;
            unst_q  <= unst_d;
        end
    end

    assign ochallenge = chal_q;
    assign opulse     = (state_q == StFire) || (state_q == StSample);
    assign obusy      = (state_q != StIdle) && (state_q != StDone);
    assign ovalid     = (state_q == StDone);
    assign oresp      = resp_q;
    assign ounstable  = unst_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench: behavioural timeline/majority model of the sequencer driven by
// constant, challenge-following, scripted and random PUF response models.
module tb_puf_challenge_sequencer;

    localparam int CL       = 16;
    localparam int RB       = 32;
    localparam int NV       = 5;
    localparam int SC       = 4;
    localparam int TC       = 8;
    localparam int PER_VOTE = SC + TC + 1;
    localparam int PER_BIT  = NV * PER_VOTE + 1;
    localparam int TOTAL    = RB * PER_BIT;

    logic          iclk = 1'b0;
    logic          irst_n = 1'b0;
    logic          istart = 1'b0;
    logic          iabort = 1'b0;
    logic          iresponse = 1'b0;
    logic          iack = 1'b0;
    logic [CL-1:0] iseed = '0;
    logic [CL-1:0] ochallenge;
    logic          opulse;
    logic          obusy;
    logic          ovalid;
    logic [RB-1:0] oresp;
    logic          ounstable;

    int            tests = 0;
    int            fails = 0;
    int            mode = 0;
    int            trk_epoch = 0;
    bit            trk_on = 1'b0;
    logic [CL-1:0] chal_m [RB+1];
    bit            vtab [RB][NV];

    puf_challenge_sequencer #(
        .C_LENGTH   (CL),
        .RESP_BITS  (RB),
        .VOTES      (NV),
        .SETUP_CYC  (SC),
        .SETTLE_CYC (TC)
    ) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .istart     (istart),
        .iseed      (iseed),
        .iabort     (iabort),
        .ochallenge (ochallenge),
        .opulse     (opulse),
        .iresponse  (iresponse),
        .obusy      (obusy),
        .ovalid     (ovalid),
        .iack       (iack),
        .oresp      (oresp),
        .ounstable  (ounstable)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Polynomial x^16+x^14+x^13+x^11+1, right-shifting Galois form.
    function automatic logic [CL-1:0] lfsr_step(input logic [CL-1:0] c);
        logic [CL-1:0] n;
        n = c >> 1;
        if (c[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic bit vote_of(input int b, input int v);
        if (mode == 0) return 1'b1;
        if (mode == 1) return chal_m[b][0];
        return vtab[b][v];
    endfunction

    function automatic int ones_of(input int b);
        int n;
        n = 0;
        for (int v = 0; v < NV; v++) n += int'(vote_of(b, v));
        return n;
    endfunction

    function automatic logic [RB-1:0] exp_resp();
        logic [RB-1:0] r;
        r = '0;
        for (int b = 0; b < RB; b++) r[b] = (2 * ones_of(b) > NV);
        return r;
    endfunction

    function automatic bit exp_unst();
        bit u;
        u = 1'b0;
        for (int b = 0; b < RB; b++) if (ones_of(b) != 0 && ones_of(b) != NV) u = 1'b1;
        return u;
    endfunction

    task automatic fill_votes(input bit noisy, input logic [NV-1:0] bit3_pat);
        for (int b = 0; b < RB; b++) begin
            bit u;
            u = bit'($urandom_range(0, 1));
            for (int v = 0; v < NV; v++) vtab[b][v] = noisy ? bit'($urandom_range(0, 1)) : u;
        end
        if (!noisy) for (int v = 0; v < NV; v++) vtab[3][v] = bit3_pat[v];
    endtask

    task automatic start_run(input int md, input logic [CL-1:0] seed);
        mode = md;
        chal_m[0] = (seed == '0) ? '1 : seed;
        for (int b = 1; b <= RB; b++) chal_m[b] = lfsr_step(chal_m[b-1]);
        @(negedge iclk);
        istart = 1'b1;
        iseed  = seed;
        @(posedge iclk);
        #1;
        istart = 1'b0;
        trk_epoch++;
        trk_on = 1'b1;
    endtask

    // cyc counts rising edges from the one that accepted istart.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!ovalid && cyc < 3000) begin
            @(posedge iclk);
            #1;
            cyc++;
        end
        check("done_reached", 64'(ovalid), 64'd1);
        if (!ovalid) begin
            iabort = 1'b1;
            @(posedge iclk);
            #1;
            iabort = 1'b0;
            trk_on = 1'b0;
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_resp"}, 64'(oresp), 64'(exp_resp()));
        check({tag, "_unstable"}, 64'(ounstable), 64'(exp_unst()));
    endtask

    task automatic ack_run(input int hold, input bit with_start);
        for (int i = 0; i < hold; i++) begin
            @(posedge iclk);
            #1;
            check("done_hold", 64'({ovalid, ounstable, oresp}), 64'({1'b1, exp_unst(), exp_resp()}));
        end
        @(negedge iclk);
        iack   = 1'b1;
        istart = with_start;
        iseed  = 16'h1234;
        @(posedge iclk);
        #1;
        iack   = 1'b0;
        istart = 1'b0;
        trk_on = 1'b0;
        check("ack_to_idle", 64'({ovalid, obusy}), 64'd0);
        repeat (3) @(posedge iclk);
        #1;
        check("no_restart", 64'({obusy, opulse}), 64'd0);
    endtask

    // Per-cycle comparison against the timeline model; also plays the PUF.
    initial begin : cmp
        int k, seen, b, r, ph;
        logic e_busy, e_pulse, e_valid;
        logic [CL-1:0] e_chal, prev_chal;
        bit prev_pulse;
        k = 0;
        seen = 0;
        prev_chal = '0;
        prev_pulse = 1'b0;
        forever begin
            @(negedge iclk);
            if (opulse && prev_pulse)
                check("chal_stable_in_pulse", 64'(ochallenge), 64'(prev_chal));
            prev_pulse = opulse;
            prev_chal  = ochallenge;
            if (trk_on) begin
                if (trk_epoch != seen) begin
                    seen = trk_epoch;
                    k = 0;
                end
                ph = -1;
                r  = 0;
                b  = 0;
                if (k < TOTAL) begin
                    b = k / PER_BIT;
                    r = k % PER_BIT;
                    e_busy  = 1'b1;
                    e_valid = 1'b0;
                    e_chal  = chal_m[b];
                    if (r == PER_BIT - 1) begin
                        e_pulse = 1'b0;
                    end else begin
                        ph = r % PER_VOTE;
                        e_pulse = (ph >= SC);
                    end
                end else begin
                    e_busy  = 1'b0;
                    e_pulse = 1'b0;
                    e_valid = 1'b1;
                    e_chal  = '0;
                end
                check("cycle", 64'({obusy, opulse, ovalid, (e_busy ? ochallenge : 16'h0)}),
                      64'({e_busy, e_pulse, e_valid, e_chal}));
                if (ph == SC)
                    iresponse = (mode == 1) ? ochallenge[0] : vote_of(b, r / PER_VOTE);
                k++;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int cyc;
        bit saw_valid;
        logic [RB-1:0] er;

        repeat (3) @(posedge iclk);
        #1;
        check("reset_outputs", 64'({ochallenge, opulse, obusy, ovalid, oresp, ounstable}), 64'd0);
        @(negedge iclk);
        irst_n = 1'b1;

        // Constant-1 PUF from seed 1.
        start_run(0, 16'h0001);
        wait_done(cyc);
        check("const1_latency", 64'(cyc), 64'd2113);
        check("const1_resp_literal", 64'(oresp), 64'hFFFF_FFFF);
        check("const1_unstable_literal", 64'(ounstable), 64'd0);
        ack_run(50, 1'b1);

        // PUF follows challenge[0]; a stray istart mid-run must be ignored.
        start_run(1, 16'h0001);
        check("model_lfsr_c1", 64'(chal_m[1]), 64'h0000_0000_0000_B400);
        check("model_lfsr_c11", 64'(chal_m[11]), 64'h0000_0000_0000_002D);
        repeat (100) @(posedge iclk);
        #1;
        istart = 1'b1;
        iseed  = 16'hABCD;
        @(posedge iclk);
        #1;
        istart = 1'b0;
        wait_done(cyc);
        check("chal0_low12_literal", 64'(oresp[11:0]), 64'h801);
        check_result("chal0");
        ack_run(2, 1'b0);

        // Scripted bit 3 votes 1,1,0,1,0 from a zero seed.
        fill_votes(1'b0, 5'b01011);
        start_run(2, 16'h0000);
        check("seed0_first_chal", 64'(ochallenge), 64'hFFFF);
        wait_done(cyc);
        check("script_a_bit3", 64'(oresp[3]), 64'd1);
        check("script_a_unstable", 64'(ounstable), 64'd1);
        check_result("script_a");
        ack_run(2, 1'b0);

        // Scripted bit 3 votes 0,0,0,0,1.
        fill_votes(1'b0, 5'b10000);
        start_run(2, CL'($urandom));
        wait_done(cyc);
        check("script_b_bit3", 64'(oresp[3]), 64'd0);
        check("script_b_unstable", 64'(ounstable), 64'd1);
        check_result("script_b");
        ack_run(2, 1'b0);

        // Fully random votes and seeds.
        for (int n = 0; n < 2; n++) begin
            fill_votes(1'b1, 5'b00000);
            start_run(3, CL'($urandom));
            wait_done(cyc);
            check_result("random");
            ack_run(3, 1'(n));
        end

        // Abort while bit 10 is being evaluated.
        fill_votes(1'b1, 5'b00000);
        start_run(3, CL'($urandom));
        repeat (10 * PER_BIT + 30) @(posedge iclk);
        #1;
        iabort = 1'b1;
        @(posedge iclk);
        #1;
        iabort = 1'b0;
        trk_on = 1'b0;
        check("abort_idle", 64'({obusy, opulse, ovalid}), 64'd0);
        er = exp_resp() & 32'h0000_03FF;
        check("abort_partial_resp", 64'(oresp), 64'(er));
        saw_valid = 1'b0;
        repeat (200) begin
            @(posedge iclk);
            #1;
            if (ovalid || obusy) saw_valid = 1'b1;
        end
        check("abort_stays_idle", 64'(saw_valid), 64'd0);
        check("abort_resp_frozen", 64'(oresp), 64'(er));

        // Asynchronous reset in the middle of FIRE.
        start_run(0, 16'h0005);
        repeat (6) @(posedge iclk);
        #1;
        check("pre_reset_in_fire", 64'({obusy, opulse}), 64'h3);
        trk_on = 1'b0;
        #1;
        irst_n = 1'b0;
        #1;
        check("reset_async_drop", 64'({opulse, ovalid, obusy}), 64'd0);
        @(negedge iclk);
        irst_n = 1'b1;
        repeat (2) @(posedge iclk);
        #1;
        check("reset_idle", 64'({obusy, opulse, ovalid, ochallenge, oresp}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
